mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Multi-cycle load/store sequencer between the pipeline MEM stage and a word-wide data RAM.
//  Accepts one access at a time (valid/ready) and issues word-aligned RAM reads/writes.
//  Sub-word stores are done as read-modify-write (RMW).
//  Loads are sign/zero-extended; misaligned or illegal accesses are reported as errors with no RAM access.
// PARAMETERS
//  DATA_WIDTH  32  data word width; only 32 supported (4 byte lanes, little-endian)
//  ADDR_WIDTH  32  byte-address width
// PORTS
//  clk_i          in   1             clock, all state on rising edge
//  rst_i          in   1             synchronous reset, active-high
//  req_valid_i    in   1             request valid
//  req_ready_o    out  1             request accepted when valid&ready
//  req_we_i       in   1             1=store, 0=load
//  req_ctrl_i     in   3             funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//  req_addr_i     in   ADDR_WIDTH    byte address
//  req_wdata_i    in   DATA_WIDTH    store data, low bits used for b/h
//  resp_valid_o   out  1             one-cycle completion pulse, no backpressure
//  resp_err_o     out  1             valid with resp_valid_o: misaligned/illegal
//  resp_rdata_o   out  DATA_WIDTH    extended load data; 0 for stores/errors
//  mem_addr_o     out  ADDR_WIDTH-2  word address = latched addr[ADDR_WIDTH-1:2]
//  mem_re_o       out  1             RAM read strobe
//  mem_we_o       out  1             RAM full-word write strobe
//  mem_wdata_o    out  DATA_WIDTH    RAM write word
//  mem_rdata_i    in   DATA_WIDTH    RAM read data, valid exactly 1 cycle after mem_re_o
// BEHAVIOUR
//  - FSM states: IDLE, READ, WAIT, WRITE, RESP. All outputs are decoded from registered state/regs.
//  - Reset: state=IDLE, all outputs 0, except req_ready_o=1 on the first cycle after reset.
//  - IDLE: req_ready_o=1. On accept, latch we/ctrl/addr/wdata.
//  - Check on accept: error if h/hu with addr[0]=1, if w with addr[1:0]!=0,
//    if ctrl is 011/110/111, or if a store has ctrl bit2=1.
//    Error -> RESP with resp_err_o=1; no mem_re_o/mem_we_o is ever issued.
//  - Load or sub-word store -> READ. Word store -> WRITE.
//  - READ: mem_re_o=1 for exactly 1 cycle -> WAIT.
//  - WAIT: capture mem_rdata_i.
//    Load: select lane by addr[1:0] (b) or addr[1] (h); sign-extend (b/h) or zero-extend (bu/hu)
//    into resp data reg -> RESP.
//    Sub-word store: merged = captured word with byte addr[1:0] or half addr[1] replaced by
//    wdata[7:0]/[15:0]; other lanes unchanged -> WRITE.
//  - WRITE: mem_we_o=1 for exactly 1 cycle. mem_wdata_o = merged word (sub-word) or wdata (sw) -> RESP.
//  - RESP: resp_valid_o=1 for 1 cycle -> IDLE.
//  - req_ready_o=0 in every non-IDLE state. New requests are never accepted during RESP.
//  - mem_re_o and mem_we_o are never high in the same cycle.
//    mem_wdata_o=0 whenever mem_we_o=0.
//  - Latency from accept edge to resp_valid_o:
//    load 3 cycles, sub-word store 4, sw 2, error 1.
//  - Throughput: 1 request per latency+1 cycles (back-to-back accepts allowed in the cycle after RESP).
//  - Reset mid-operation (any state): next cycle IDLE; pending write is dropped.
//    No mem_we_o and no resp_valid_o for the aborted request.
//  - Address wrap: no address arithmetic; the word address is a pure slice, so there is no carry.
//  - req_* inputs are ignored while req_ready_o=0.
// TESTING
//  1. RAM[0x40]=0x8899AABB; lb addr 0x101 -> resp_rdata_o=0xFFFFFFAA, err=0, resp 3 cycles after accept.
//  2. Same word; lhu 0x102 -> 0x00008899; lh 0x102 -> 0xFFFF8899; lw 0x100 -> 0x8899AABB.
//  3. sb 0x103 wdata 0x12 -> one mem_re_o, then mem_we_o with mem_wdata_o=0x1299AABB at cycle 3;
//     sh 0x100 wdata 0xCAFE -> 0x8899CAFE.
//  4. sw 0x104 wdata 0xDEADBEEF -> no mem_re_o; mem_we_o at cycle 1 with mem_addr_o=0x41; resp at cycle 2.
//  5. lh 0x101, sw 0x102, ctrl 011, sbu-store (ctrl 100, we=1) -> resp_err_o=1 at cycle 1, no RAM strobes.
//  6. rst_i asserted during WAIT of sb -> IDLE next cycle, no mem_we_o, no resp; a following lw completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundle of the request, response and RAM signals of mem_access_unit.
//   slave  : view of the sequencer (receives req_*, mem_rdata_i; drives the rest)
//   master : view of the pipeline + RAM side (testbench or surrounding logic)
// Signal names keep the sequencer's point of view (_i into it, _o out of it).
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_ctrl_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  resp_valid_o;
    logic                  resp_err_o;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic [ADDR_WIDTH-3:0] mem_addr_o;
    logic                  mem_re_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_ctrl_i, req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
               mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_ctrl_i, req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o,
               mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store sequencer between the MEM stage and a word-wide RAM.
// One access in flight at a time; sub-word stores are done as read-modify-write,
// loads are sign/zero-extended, misaligned/illegal accesses respond with an error
// and never touch the RAM.
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_i  : synchronous active-high reset
//   bus    : mem_access_unit_if.slave (request, response, RAM strobes/data)
// Only DATA_WIDTH = 32 (4 little-endian byte lanes) is supported.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_access_unit_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    state_t                state_q;
    logic                  we_q;
    logic [2:0]            ctrl_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] sdata_q;   // store data latched at accept
    logic                  ready_q;
    logic                  re_q;
    logic                  mwe_q;
    logic [DATA_WIDTH-1:0] mwdata_q;
    logic                  valid_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  req_err_d;
    logic [DATA_WIDTH-1:0] load_d;
    logic [DATA_WIDTH-1:0] merged_d;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    // Access legality of the incoming request, judged at accept time.
    always_comb begin
        req_err_d = 1'b0;
        case (bus.req_ctrl_i)
            3'b000, 3'b100: req_err_d = 1'b0;
            3'b001, 3'b101: req_err_d = bus.req_addr_i[0];
            3'b010:         req_err_d = (bus.req_addr_i[1:0] != 2'b00);
            default:        req_err_d = 1'b1;
        endcase
        // Unsigned variants have no meaning for stores.
        if (bus.req_we_i && bus.req_ctrl_i[2])
            req_err_d = 1'b1;
    end

    // Lane extraction/extension for loads and lane merge for sub-word stores,
    // both working on the word arriving from the RAM during WAIT.
    always_comb begin
        byte_sel = bus.mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        half_sel = bus.mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (ctrl_q)
            3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_d = {24'd0, byte_sel};
            3'b101:  load_d = {16'd0, half_sel};
            default: load_d = bus.mem_rdata_i;
        endcase
        merged_d = bus.mem_rdata_i;
        if (ctrl_q[1:0] == 2'b00)
            merged_d[{addr_q[1:0], 3'b000} +: 8] = sdata_q[7:0];
        else
            merged_d[{addr_q[1], 4'b0000} +: 16] = sdata_q[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Dropping everything here also discards a pending RMW write.
            state_q  <= IDLE;
            we_q     <= 1'b0;
            ctrl_q   <= 3'b000;
            addr_q   <= '0;
            sdata_q  <= '0;
            ready_q  <= 1'b1;
            re_q     <= 1'b0;
            mwe_q    <= 1'b0;
            mwdata_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        we_q    <= bus.req_we_i;
                        ctrl_q  <= bus.req_ctrl_i;
                        addr_q  <= bus.req_addr_i;
                        sdata_q <= bus.req_wdata_i;
                        ready_q <= 1'b0;
                        if (req_err_d) begin
                            valid_q <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end else if (bus.req_we_i && bus.req_ctrl_i == 3'b010) begin
                            mwe_q    <= 1'b1;
                            mwdata_q <= bus.req_wdata_i;
                            state_q  <= WRITE;
                        end else begin
                            re_q    <= 1'b1;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    re_q    <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (we_q) begin
                        mwe_q    <= 1'b1;
                        mwdata_q <= merged_d;
                        state_q  <= WRITE;
                    end else begin
                        rdata_q <= load_d;
                        valid_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                WRITE: begin
                    mwe_q    <= 1'b0;
                    mwdata_q <= '0;
                    valid_q  <= 1'b1;
                    state_q  <= RESP;
                end
                RESP: begin
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = ready_q;
    assign bus.resp_valid_o = valid_q;
    assign bus.resp_err_o   = err_q;
    assign bus.resp_rdata_o = rdata_q;
    assign bus.mem_addr_o   = addr_q[ADDR_WIDTH-1:2];
    assign bus.mem_re_o     = re_q;
    assign bus.mem_we_o     = mwe_q;
    assign bus.mem_wdata_o  = mwdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a 256-word RAM model answers the
// strobes, each accepted request pushes its expected outcome, and a negedge
// monitor compares RAM traffic and responses against the queue head.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst_i;
    logic ram_init;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          n_re;
        int          n_we;
        int          lat_we;
        logic [31:0] wword;
        logic [31:0] waddr;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ram [0:255];
    logic [31:0] last_rdata;
    logic        last_err;
    int          re_cnt = 0;
    int          we_cnt = 0;
    int          we_tot = 0;
    int          resp_tot = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // RAM model: read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++)
                ram[i] <= 32'h5A3C_96E1 ^ (i * 32'h0103_0507);
            ram[8'h40] <= 32'h8899_AABB;
        end else begin
            if (bus.mem_re_o) bus.mem_rdata_i <= ram[bus.mem_addr_o[7:0]];
            if (bus.mem_we_o) ram[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;
        end
    end

    // Reference behaviour, computed from the RAM contents at accept time.
    function automatic exp_t model(input logic we, input logic [2:0] ctrl,
                                   input logic [31:0] a, input logic [31:0] wd, input int acc);
        exp_t        e;
        logic        bad;
        logic [31:0] w, sh, m;
        e = '{err: 1'b0, rdata: 32'd0, lat: 1, n_re: 0, n_we: 0, lat_we: 0,
              wword: 32'd0, waddr: {2'b00, a[31:2]}, acc: acc};
        w  = ram[a[9:2]];
        sh = w >> (8 * a[1:0]);
        case (ctrl)
            3'b000, 3'b100: bad = we && ctrl[2];
            3'b001, 3'b101: bad = a[0] || (we && ctrl[2]);
            3'b010:         bad = (a[1:0] != 2'b00);
            default:        bad = 1'b1;
        endcase
        if (bad) begin
            e.err = 1'b1;
        end else if (!we) begin
            e.lat = 3; e.n_re = 1;
            case (ctrl)
                3'b000:  e.rdata = {{24{sh[7]}}, sh[7:0]};
                3'b100:  e.rdata = {24'd0, sh[7:0]};
                3'b001:  e.rdata = {{16{sh[15]}}, sh[15:0]};
                3'b101:  e.rdata = {16'd0, sh[15:0]};
                default: e.rdata = w;
            endcase
        end else if (ctrl == 3'b010) begin
            e.lat = 2; e.n_we = 1; e.lat_we = 1; e.wword = wd;
        end else begin
            e.lat = 4; e.n_re = 1; e.n_we = 1; e.lat_we = 3;
            m = (ctrl[0] ? 32'h0000_FFFF : 32'h0000_00FF) << (8 * a[1:0]);
            e.wword = (w & ~m) | ((wd << (8 * a[1:0])) & m);
        end
        return e;
    endfunction

    // Monitor: protocol invariants every cycle, traffic and responses vs queue head.
    always @(negedge clk) begin
        if (rst_i) begin
            q.delete();
            re_cnt = 0;
            we_cnt = 0;
        end else begin
            chk("re_we_excl", {31'd0, bus.mem_re_o & bus.mem_we_o}, 32'd0);
            if (!bus.mem_we_o) chk("wdata_idle", bus.mem_wdata_o, 32'd0);
            if (bus.mem_re_o) begin
                re_cnt++;
                if (q.size() > 0) chk("re_addr", {2'b00, bus.mem_addr_o}, q[0].waddr);
                else chk("re_no_req", 32'd1, 32'd0);
            end
            if (bus.mem_we_o) begin
                we_cnt++;
                we_tot++;
                if (q.size() > 0) begin
                    chk("we_addr", {2'b00, bus.mem_addr_o}, q[0].waddr);
                    chk("we_data", bus.mem_wdata_o, q[0].wword);
                    chk("we_lat", cyc - q[0].acc, q[0].lat_we);
                end else chk("we_no_req", 32'd1, 32'd0);
            end
            if (bus.resp_valid_o) begin
                resp_tot++;
                last_rdata = bus.resp_rdata_o;
                last_err   = bus.resp_err_o;
                if (q.size() == 0) chk("resp_no_req", 32'd1, 32'd0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_err", {31'd0, bus.resp_err_o}, {31'd0, e.err});
                    chk("resp_rdata", bus.resp_rdata_o, e.rdata);
                    chk("resp_lat", cyc - e.acc, e.lat);
                    chk("n_re", re_cnt, e.n_re);
                    chk("n_we", we_cnt, e.n_we);
                    chk("ready_resp", {31'd0, bus.req_ready_o}, 32'd0);
                end
                re_cnt = 0;
                we_cnt = 0;
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_ctrl_i  = ctrl;
        bus.req_addr_i  = a;
        bus.req_wdata_i = wd;
        while (!bus.req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready_o) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid_i = 1'b0;
            return;
        end
        q.push_back(model(we, ctrl, a, wd, cyc));
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("resp_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic req_chk(input string tag, input logic we, input logic [2:0] ctrl,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic err, input logic [31:0] rd);
        do_req(we, ctrl, a, wd);
        wait_idle();
        chk({tag, "_err"}, {31'd0, last_err}, {31'd0, err});
        chk({tag, "_data"}, last_rdata, rd);
    endtask

    initial begin
        int acc, we0, rs0;
        rst_i = 1'b1;
        ram_init = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_ctrl_i  = 3'b000;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;
        chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, bus.resp_valid_o}, 32'd0);
        chk("rst_err", {31'd0, bus.resp_err_o}, 32'd0);
        chk("rst_rdata", bus.resp_rdata_o, 32'd0);
        chk("rst_strobes", {30'd0, bus.mem_re_o, bus.mem_we_o}, 32'd0);
        chk("rst_addr", {2'b00, bus.mem_addr_o}, 32'd0);
        #1 rst_i = 1'b0;

        // Loads from word 0x40 = 0x8899AABB
        req_chk("lb",  1'b0, 3'b000, 32'h101, 32'h0, 1'b0, 32'hFFFF_FFAA);
        req_chk("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 1'b0, 32'h0000_8899);
        req_chk("lh",  1'b0, 3'b001, 32'h102, 32'h0, 1'b0, 32'hFFFF_8899);
        req_chk("lw",  1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h8899_AABB);
        req_chk("lbu", 1'b0, 3'b100, 32'h100, 32'h0, 1'b0, 32'h0000_00BB);

        // Sub-word stores (RMW) and word stores, read back
        req_chk("sb",     1'b1, 3'b000, 32'h103, 32'h0000_0012, 1'b0, 32'h0);
        req_chk("sb_rd",  1'b0, 3'b010, 32'h100, 32'h0,         1'b0, 32'h1299_AABB);
        req_chk("sw_rst", 1'b1, 3'b010, 32'h100, 32'h8899_AABB, 1'b0, 32'h0);
        req_chk("sh",     1'b1, 3'b001, 32'h100, 32'h0000_CAFE, 1'b0, 32'h0);
        req_chk("sh_rd",  1'b0, 3'b010, 32'h100, 32'h0,         1'b0, 32'h8899_CAFE);
        req_chk("sw",     1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 1'b0, 32'h0);
        req_chk("sw_rd",  1'b0, 3'b010, 32'h104, 32'h0,         1'b0, 32'hDEAD_BEEF);

        // Errors: no RAM strobes (checked by monitor counts)
        req_chk("e_lh",  1'b0, 3'b001, 32'h101, 32'h0, 1'b1, 32'h0);
        req_chk("e_sw",  1'b1, 3'b010, 32'h102, 32'h1, 1'b1, 32'h0);
        req_chk("e_011", 1'b0, 3'b011, 32'h100, 32'h0, 1'b1, 32'h0);
        req_chk("e_sbu", 1'b1, 3'b100, 32'h100, 32'h5, 1'b1, 32'h0);
        req_chk("e_110", 1'b0, 3'b110, 32'h100, 32'h0, 1'b1, 32'h0);

        // Top of address space: word address is a pure slice
        req_chk("lbu_top", 1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0, 1'b0,
                {24'd0, ram[8'hFF][31:24]});

        // Reset during WAIT of a sub-word store
        req_chk("sw_rst2", 1'b1, 3'b010, 32'h100, 32'h8899_AABB, 1'b0, 32'h0);
        do_req(1'b1, 3'b000, 32'h103, 32'h0000_0012);
        acc = q[0].acc;
        while (cyc < acc + 2) @(negedge clk);
        #1 rst_i = 1'b1;
        we0 = we_tot;
        rs0 = resp_tot;
        @(negedge clk);
        #1 rst_i = 1'b0;
        chk("abort_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("abort_we", {31'd0, bus.mem_we_o}, 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_no_we", we_tot, we0);
        chk("abort_no_resp", resp_tot, rs0);
        req_chk("abort_lw", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'h8899_AABB);

        // Random back-to-back traffic
        for (int i = 0; i < 60; i++)
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 1023)), $urandom);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
